rob_rsp_sel: RTL and testbench

- Responder end of the per-channel load-order interface (rob_req / rob_ack / rob_bank_id).
- Buffers load responses that arrive out of order from the memory banks, one small FIFO per bank.
- Pops the response for the bank named by the oldest outstanding load, acks the order tracker, and returns data to the upstream channel strictly in issue order.
- One instance per xbar channel (ch_0..ch_2).

---
 rtl/rob_rsp_sel_pkg.sv | 15 +
 rtl/rob_rsp_sel_if.sv | 25 ++
 rtl/rob_rsp_sel_bank_fifo.sv | 71 +++++++
 rtl/rob_rsp_sel.sv | 82 ++++++++
 tb/tb_rob_rsp_sel.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/rob_rsp_sel_pkg.sv
// Shared types and sizing for the in-order load response selector.
// The bank_id space matches the order tracker, which takes bank_id from addr[9:8].
package rob_rsp_sel_pkg;

  localparam int NumBanks     = 4;
  localparam int BankIdWidth  = 2;
  localparam int DataWidth    = 64;
  localparam int FifoDepth    = 4;
  localparam int FifoPtrWidth = 2;

  typedef struct packed {
    logic [DataWidth-1:0] data;
  } rob_rsp_t;

endpackage

// File: rtl/rob_rsp_sel_if.sv
// Load-order, bank response and upstream response signals of one xbar channel.
interface rob_rsp_sel_if;
  import rob_rsp_sel_pkg::*;

  logic                                rob_req;
  logic [BankIdWidth-1:0]              rob_bank_id;
  logic                                rob_ack;
  logic [NumBanks-1:0]                 bank_rsp_valid;
  logic [NumBanks-1:0][DataWidth-1:0]  bank_rsp_data;
  logic [NumBanks-1:0]                 bank_rsp_ready;
  logic                                u_rsp_valid;
  logic [DataWidth-1:0]                u_rsp_data;
  logic                                u_rsp_ready;

  modport slave (
    input  rob_req, rob_bank_id, bank_rsp_valid, bank_rsp_data, u_rsp_ready,
    output rob_ack, bank_rsp_ready, u_rsp_valid, u_rsp_data
  );

  modport master (
    output rob_req, rob_bank_id, bank_rsp_valid, bank_rsp_data, u_rsp_ready,
    input  rob_ack, bank_rsp_ready, u_rsp_valid, u_rsp_data
  );

endinterface

// File: rtl/rob_rsp_sel_bank_fifo.sv
// Per-bank response FIFO using pointer-plus-wrap-flag full/empty detection.
// Full/empty come from registered pointers only, so ready has no combinational path from pop.
module rob_rsp_sel_bank_fifo
  import rob_rsp_sel_pkg::*;
#(
  parameter int Depth    = FifoDepth,
  parameter int PtrWidth = FifoPtrWidth
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  rob_rsp_t push_rsp,
  input  logic     pop,
  output rob_rsp_t head_rsp,
  output logic     full,
  output logic     empty
);

  localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(Depth - 1);

  logic [PtrWidth-1:0] wr_ptr;
  logic [PtrWidth-1:0] rd_ptr;
  logic                wr_flag;
  logic                rd_flag;
  logic                do_push;
  logic                do_pop;
  rob_rsp_t            mem [Depth];

  assign empty   = (wr_ptr == rd_ptr) && (wr_flag == rd_flag);
  assign full    = (wr_ptr == rd_ptr) && (wr_flag != rd_flag);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      wr_flag <= 1'b0;
    end else if (do_push) begin
      if (wr_ptr == LastPtr) begin
        wr_ptr  <= '0;
        wr_flag <= ~wr_flag;
      end else begin
        wr_ptr <= wr_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      rd_flag <= 1'b0;
    end else if (do_pop) begin
      if (rd_ptr == LastPtr) begin
        rd_ptr  <= '0;
        rd_flag <= ~rd_flag;
      end else begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Storage needs no reset: nothing is read out unless the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_rsp;
    end
  end

  assign head_rsp = mem[rd_ptr];

endmodule

// File: rtl/rob_rsp_sel.sv
// Buffers out-of-order bank responses and returns them upstream in load issue order,
// retiring the oldest load (rob_ack) when its bank has data and the out register is free.
module rob_rsp_sel
  import rob_rsp_sel_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  rob_rsp_sel_if.slave  bus
);

  logic [NumBanks-1:0] full;
  logic [NumBanks-1:0] empty;
  logic [NumBanks-1:0] push;
  logic [NumBanks-1:0] pop;
  rob_rsp_t            head_rsp [NumBanks];

  rob_rsp_t            sel_rsp;
  logic                sel_empty;
  logic                id_in_range;
  logic                out_free;
  logic                ack;
  logic                out_vld;
  logic [DataWidth-1:0] out_data;

  for (genvar g = 0; g < NumBanks; g++) begin : g_bank
    assign push[g] = bus.bank_rsp_valid[g] && !full[g];
    assign pop[g]  = ack && (bus.rob_bank_id == BankIdWidth'(g));

    rob_rsp_sel_bank_fifo u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push[g]),
      .push_rsp (rob_rsp_t'(bus.bank_rsp_data[g])),
      .pop      (pop[g]),
      .head_rsp (head_rsp[g]),
      .full     (full[g]),
      .empty    (empty[g])
    );
  end

  assign bus.bank_rsp_ready = ~full;

  // An id with no matching bank reads as empty, so it can never be acked.
  always_comb begin
    sel_rsp   = '0;
    sel_empty = 1'b1;
    for (int b = 0; b < NumBanks; b++) begin
      if (bus.rob_bank_id == BankIdWidth'(b)) begin
        sel_rsp   = head_rsp[b];
        sel_empty = empty[b];
      end
    end
  end

  assign id_in_range = (32'(bus.rob_bank_id) < NumBanks);
  assign out_free    = !out_vld || bus.u_rsp_ready;
  assign ack         = bus.rob_req && id_in_range && !sel_empty && out_free;
  assign bus.rob_ack = ack;

  // A new ack refills the register in the same cycle the old response leaves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld  <= 1'b0;
      out_data <= '0;
    end else if (ack) begin
      out_vld  <= 1'b1;
      out_data <= sel_rsp.data;
    end else if (bus.u_rsp_ready) begin
      out_vld <= 1'b0;
    end
  end

  assign bus.u_rsp_valid = out_vld;
  assign bus.u_rsp_data  = out_data;

  a_bank_id_in_range: assert property (@(posedge clk) disable iff (!rst_n)
    bus.rob_req |-> id_in_range);

  a_no_ack_without_req: assert property (@(posedge clk) disable iff (!rst_n)
    ack |-> bus.rob_req);

endmodule

// File: tb/tb_rob_rsp_sel.sv
// Directed bench for rob_rsp_sel: a scoreboard queue holds the in-order responses expected upstream.
module tb_rob_rsp_sel;
  import rob_rsp_sel_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rob_rsp_sel_if bus();

  rob_rsp_sel dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int                   vectors     = 0;
  int                   miscompares = 0;
  logic [DataWidth-1:0] exp_q [$];

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // bank < 0 means no bank response this cycle.
  task automatic apply_stimulus(input int bank, input logic [63:0] data, input logic req, input logic [1:0] id);
    bus.bank_rsp_valid = '0;
    bus.bank_rsp_data  = '0;
    if (bank >= 0) begin
      bus.bank_rsp_valid[bank] = 1'b1;
      bus.bank_rsp_data[bank]  = data;
    end
    bus.rob_req     = req;
    bus.rob_bank_id = id;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Monitor: every upstream handshake pops the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.u_rsp_valid && bus.u_rsp_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_rsp: got 0x%0h, expected no response at %0t", bus.u_rsp_data, $time);
        end else begin
          check_output("rsp_data", bus.u_rsp_data, exp_q.pop_front());
        end
      end
      if (!bus.rob_req) check_output("ack_without_req", 64'(bus.rob_ack), 64'd0);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n           = 1'b0;
    bus.u_rsp_ready = 1'b1;
    apply_stimulus(-1, 0, 1'b0, 2'd0);
    repeat (2) @(posedge clk);
    mid();
    check_output("reset_valid", 64'(bus.u_rsp_valid), 64'd0);
    check_output("reset_data", bus.u_rsp_data, 64'd0);
    check_output("reset_ready", 64'(bus.bank_rsp_ready), 64'hF);
    check_output("reset_ack", 64'(bus.rob_ack), 64'd0);
    rst_n = 1'b1;
    step();

    $display("[TB] basic bank2 response");
    exp_q.push_back(64'hA5);
    apply_stimulus(2, 64'hA5, 1'b1, 2'd2);
    mid(); check_output("t1_ack_before_push", 64'(bus.rob_ack), 64'd0); step();
    apply_stimulus(-1, 0, 1'b1, 2'd2);
    mid(); check_output("t1_ack", 64'(bus.rob_ack), 64'd1);
    check_output("t1_valid_early", 64'(bus.u_rsp_valid), 64'd0); step();
    apply_stimulus(-1, 0, 1'b0, 2'd2);
    mid(); check_output("t1_valid", 64'(bus.u_rsp_valid), 64'd1);
    check_output("t1_data", bus.u_rsp_data, 64'hA5); step();
    mid(); check_output("t1_idle", 64'(bus.u_rsp_valid), 64'd0); step();

    $display("[TB] out-of-order return");
    exp_q.push_back(64'h22);
    exp_q.push_back(64'h11);
    apply_stimulus(0, 64'h11, 1'b1, 2'd1);
    mid(); check_output("t2_ack_empty0", 64'(bus.rob_ack), 64'd0); step();
    apply_stimulus(1, 64'h22, 1'b1, 2'd1);
    mid(); check_output("t2_no_ack_head_empty", 64'(bus.rob_ack), 64'd0); step();
    apply_stimulus(-1, 0, 1'b1, 2'd1);
    mid(); check_output("t2_ack_bank1", 64'(bus.rob_ack), 64'd1); step();
    apply_stimulus(-1, 0, 1'b1, 2'd0);
    mid(); check_output("t2_ack_bank0", 64'(bus.rob_ack), 64'd1);
    check_output("t2_first_data", bus.u_rsp_data, 64'h22); step();
    apply_stimulus(-1, 0, 1'b0, 2'd0);
    mid(); check_output("t2_second_data", bus.u_rsp_data, 64'h11); step();
    mid(); check_output("t2_idle", 64'(bus.u_rsp_valid), 64'd0); step();

    $display("[TB] upstream backpressure");
    for (int i = 1; i <= 4; i++) exp_q.push_back(64'h30 + 64'(i));
    bus.u_rsp_ready = 1'b0;
    apply_stimulus(3, 64'h31, 1'b1, 2'd3);
    mid(); step();
    apply_stimulus(3, 64'h32, 1'b1, 2'd3);
    mid(); check_output("t3_first_ack", 64'(bus.rob_ack), 64'd1); step();
    apply_stimulus(3, 64'h33, 1'b1, 2'd3);
    mid(); check_output("t3_stall_ack", 64'(bus.rob_ack), 64'd0);
    check_output("t3_hold_data", bus.u_rsp_data, 64'h31); step();
    apply_stimulus(3, 64'h34, 1'b1, 2'd3);
    mid(); check_output("t3_stall_ack2", 64'(bus.rob_ack), 64'd0);
    check_output("t3_hold_data2", bus.u_rsp_data, 64'h31); step();
    apply_stimulus(-1, 0, 1'b1, 2'd3);
    bus.u_rsp_ready = 1'b1;
    mid(); check_output("t3_ack_on_ready", 64'(bus.rob_ack), 64'd1); step();
    mid(); check_output("t3_stream_ack1", 64'(bus.rob_ack), 64'd1);
    check_output("t3_stream_valid1", 64'(bus.u_rsp_valid), 64'd1); step();
    mid(); check_output("t3_stream_ack2", 64'(bus.rob_ack), 64'd1);
    check_output("t3_stream_valid2", 64'(bus.u_rsp_valid), 64'd1); step();
    apply_stimulus(-1, 0, 1'b0, 2'd3);
    mid(); check_output("t3_stream_valid3", 64'(bus.u_rsp_valid), 64'd1); step();
    mid(); check_output("t3_idle", 64'(bus.u_rsp_valid), 64'd0); step();

    $display("[TB] bank0 full and pointer wrap");
    for (int i = 1; i <= 6; i++) exp_q.push_back(64'h40 + 64'(i));
    apply_stimulus(0, 64'h41, 1'b0, 2'd0);
    mid(); check_output("t4_ready_empty", 64'(bus.bank_rsp_ready), 64'hF); step();
    apply_stimulus(0, 64'h42, 1'b0, 2'd0); step();
    apply_stimulus(0, 64'h43, 1'b0, 2'd0); step();
    apply_stimulus(0, 64'h44, 1'b0, 2'd0); step();
    apply_stimulus(0, 64'h4F, 1'b0, 2'd0);
    mid(); check_output("t4_full", 64'(bus.bank_rsp_ready), 64'hE); step();
    apply_stimulus(-1, 0, 1'b1, 2'd0);
    mid(); check_output("t4_pop_ack", 64'(bus.rob_ack), 64'd1);
    check_output("t4_full_during_pop", 64'(bus.bank_rsp_ready), 64'hE); step();
    apply_stimulus(0, 64'h45, 1'b1, 2'd0);
    mid(); check_output("t4_ready_after_pop", 64'(bus.bank_rsp_ready), 64'hF);
    check_output("t4_ack2", 64'(bus.rob_ack), 64'd1); step();
    apply_stimulus(0, 64'h46, 1'b1, 2'd0);
    mid(); check_output("t4_ack3", 64'(bus.rob_ack), 64'd1); step();
    apply_stimulus(-1, 0, 1'b1, 2'd0);
    for (int i = 0; i < 3; i++) begin
      mid(); check_output("t4_drain_ack", 64'(bus.rob_ack), 64'd1); step();
    end
    apply_stimulus(-1, 0, 1'b0, 2'd0);
    mid(); check_output("t4_last_data", bus.u_rsp_data, 64'h46); step();
    mid(); check_output("t4_idle", 64'(bus.u_rsp_valid), 64'd0); step();

    $display("[TB] same-cycle push and pop");
    exp_q.push_back(64'h51);
    exp_q.push_back(64'h52);
    apply_stimulus(1, 64'h51, 1'b0, 2'd1);
    mid(); step();
    apply_stimulus(1, 64'h52, 1'b1, 2'd1);
    mid(); check_output("t5_ack", 64'(bus.rob_ack), 64'd1);
    check_output("t5_ready", 64'(bus.bank_rsp_ready), 64'hF); step();
    apply_stimulus(-1, 0, 1'b1, 2'd1);
    mid(); check_output("t5_count_one", 64'(bus.rob_ack), 64'd1); step();
    mid(); check_output("t5_empty_after", 64'(bus.rob_ack), 64'd0); step();
    apply_stimulus(-1, 0, 1'b0, 2'd1);
    mid(); check_output("t5_idle", 64'(bus.u_rsp_valid), 64'd0); step();

    $display("[TB] async reset mid-stream");
    bus.u_rsp_ready = 1'b0;
    apply_stimulus(2, 64'h61, 1'b1, 2'd2);
    mid(); step();
    apply_stimulus(2, 64'h62, 1'b1, 2'd2);
    mid(); check_output("t6_ack", 64'(bus.rob_ack), 64'd1); step();
    apply_stimulus(2, 64'h63, 1'b1, 2'd2); step();
    apply_stimulus(2, 64'h64, 1'b1, 2'd2); step();
    apply_stimulus(-1, 0, 1'b1, 2'd2);
    mid(); check_output("t6_pre_valid", 64'(bus.u_rsp_valid), 64'd1);
    check_output("t6_pre_data", bus.u_rsp_data, 64'h61);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("t6_rst_valid", 64'(bus.u_rsp_valid), 64'd0);
    check_output("t6_rst_data", bus.u_rsp_data, 64'd0);
    check_output("t6_rst_ready", 64'(bus.bank_rsp_ready), 64'hF);
    check_output("t6_rst_ack", 64'(bus.rob_ack), 64'd0);
    apply_stimulus(-1, 0, 1'b0, 2'd2);
    step();
    rst_n           = 1'b1;
    bus.u_rsp_ready = 1'b1;
    apply_stimulus(-1, 0, 1'b1, 2'd2);
    for (int i = 0; i < 4; i++) begin
      mid();
      check_output("t6_post_valid", 64'(bus.u_rsp_valid), 64'd0);
      check_output("t6_post_ack", 64'(bus.rob_ack), 64'd0);
      step();
    end
    apply_stimulus(-1, 0, 1'b0, 2'd0);
    mid(); step();

    check_output("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
